// File: rtl/cnn_pkg.sv
// Shared widths, operand/accumulator types and pipeline timing for the 3x3 convolution engine.
package cnn_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ACC_W       = 32;
  // Cycles from an enabled a/b pair until its term is visible in acc.
  localparam int unsigned MAC_LATENCY = 2;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/relu_stage.sv
// Combinational ReLU clamp: negative values become zero, all others pass unchanged.
module relu_stage #(
  parameter int unsigned W = cnn_pkg::ACC_W
) (
  input  logic signed [W-1:0] i_val,
  output logic signed [W-1:0] o_val_c
);

  assign o_val_c = i_val[W-1] ? '0 : i_val;

endmodule

// File: rtl/mac_relu_datapath.sv
// Two-stage pipelined signed multiply-accumulate with a combinational ReLU on the accumulator.
module mac_relu_datapath #(
  parameter int unsigned DATA_W = cnn_pkg::DATA_W,
  parameter int unsigned ACC_W  = cnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  relu_acc
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_prod_q;
  logic                    r_prod_v;
  logic signed [ACC_W-1:0] r_acc;

  // Full-width signed product, truncated to the accumulator width.
  assign w_prod = ACC_W'(PROD_W'(a) * PROD_W'(b));

  // Stage 1: product register and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
    end else begin
      r_prod_q <= w_prod;
      r_prod_v <= enable;
    end
  end

  // Stage 2: wrapping accumulate; holds whenever no valid product is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (r_prod_v) begin
      r_acc <= r_acc + r_prod_q;
    end
  end

  assign acc = r_acc;

  relu_stage #(
    .W(ACC_W)
  ) u_relu (
    .i_val  (r_acc),
    .o_val_c(relu_acc)
  );

endmodule

// File: tb/tb_mac_relu_datapath.sv
// Self-checking bench: directed kernel cases plus random streams against a term-list reference model.
module tb_mac_relu_datapath;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [31:0] acc;
  logic signed [31:0] relu_acc;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Each accepted term remembers the edge it was sampled at.
  typedef struct {
    int          e;
    logic [31:0] p;
  } term_t;
  term_t tq[$];

  mac_relu_datapath #(
    .DATA_W(32),
    .ACC_W (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .a       (a),
    .b       (b),
    .acc     (acc),
    .relu_acc(relu_acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected acc after edge k: wrapped sum of terms sampled at or before edge k-1 since the last reset.
  function automatic logic [31:0] model_acc();
    logic [31:0] s = '0;
    foreach (tq[i]) if (tq[i].e <= edge_n - 1) s = s + tq[i].p;
    return s;
  endfunction

  task automatic step(input logic r, input logic en, input logic [31:0] av, input logic [31:0] bv);
    longint      pl;
    logic [31:0] ex;
    term_t       t;
    rst    = r;
    enable = en;
    a      = av;
    b      = bv;
    @(posedge clk);
    edge_n++;
    if (r) begin
      tq.delete();
    end else if (en) begin
      pl  = longint'($signed(av)) * longint'($signed(bv));
      t.e = edge_n;
      t.p = pl[31:0];
      tq.push_back(t);
    end
    #1;
    ex = model_acc();
    chk("model_acc", acc, ex);
    chk("model_relu", relu_acc, ex[31] ? 32'd0 : ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd99, 32'd99);
  endtask

  initial begin
    int          kern[9];
    int          pix1[9];
    int          pix2[9];
    logic        r;
    logic        en;
    logic [31:0] av;
    logic [31:0] bv;
    kern = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    pix1 = '{10, 10, 10, 5, 5, 5, 20, 20, 20};
    pix2 = '{20, 20, 20, 7, 7, 7, 10, 10, 10};
    rst = 1'b1; enable = 1'b0; a = '0; b = '0;

    // Reset state
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("reset_acc", acc, 32'd0);
    chk("reset_relu", relu_acc, 32'd0);

    // Edge kernel, positive response
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(pix1[i]), 32'(kern[i]));
    idle(1);
    chk("edge_pos_acc", acc, 32'd30);
    chk("edge_pos_relu", relu_acc, 32'd30);

    // Edge kernel, negative response
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(pix2[i]), 32'(kern[i]));
    idle(1);
    chk("edge_neg_acc", acc, 32'hFFFF_FFE2);
    chk("edge_neg_relu", relu_acc, 32'd0);

    // Latency and hold
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd3, 32'd4);
    chk("lat_first_edge", acc, 32'd0);
    idle(1);
    chk("lat_second_edge", acc, 32'd12);
    idle(9);
    chk("hold_acc", acc, 32'd12);

    // Wrap-around
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd2);
    idle(1);
    chk("wrap_acc", acc, 32'hFFFF_FFFE);
    chk("wrap_relu", relu_acc, 32'd0);
    step(1'b0, 1'b1, 32'd1, 32'd3);
    idle(1);
    chk("wrap_recover_acc", acc, 32'd1);
    chk("wrap_recover_relu", relu_acc, 32'd1);

    // Reset mid-accumulation, colliding with an enabled term
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd5, 32'd5);
    step(1'b0, 1'b1, 32'd5, 32'd5);
    step(1'b1, 1'b1, 32'd5, 32'd5);
    chk("midrst_acc", acc, 32'd0);
    idle(1);
    chk("midrst_flushed", acc, 32'd0);
    step(1'b0, 1'b1, 32'd2, 32'd3);
    idle(1);
    chk("midrst_after", acc, 32'd6);

    // Back-to-back pixels with per-pixel reset
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd1, 32'd1);
    step(1'b0, 1'b1, 32'd2, 32'd2);
    step(1'b0, 1'b1, 32'd3, 32'd3);
    idle(1);
    chk("b2b_sum1_acc", acc, 32'd14);
    chk("b2b_sum1_relu", relu_acc, 32'd14);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("b2b_rst_acc", acc, 32'd0);
    chk("b2b_rst_relu", relu_acc, 32'd0);
    step(1'b0, 1'b1, -32'sd4, 32'd2);
    idle(1);
    chk("b2b_sum2_acc", acc, 32'hFFFF_FFF8);
    chk("b2b_sum2_relu", relu_acc, 32'd0);

    // Random streams: mixed enable density, occasional reset, small and full-range operands
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        av = 32'($signed($urandom_range(0, 255)) - 128);
        bv = 32'($signed($urandom_range(0, 255)) - 128);
      end else begin
        av = $urandom;
        bv = $urandom;
      end
      step(r, en, av, bv);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
